// File: rtl/riscv_core_pipe_ctrl_pkg.sv
// Shared types and defaults for the pipeline-control unit.
//   flush_state_e : flush sequencer states
//   DEF_*         : default parameter values
//   clog2_min1    : ceil(log2(n)) with a floor of 1, so index and counter widths never collapse to 0
package riscv_core_pipe_ctrl_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } flush_state_e;

  localparam int DEF_NUM_STAGES  = 5;
  localparam int DEF_AUTO_BUBBLE = 1;
  localparam int DEF_FLUSH_HOLD  = 2;
  localparam int DEF_WDOG_LIMIT  = 64;
  localparam int DEF_CNT_W       = 32;

  function automatic int clog2_min1(input int n);
    int r;
    r = $clog2(n);
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/riscv_core_pipe_ctrl_flush_fsm.sv
// Flush sequencer: after a flush request, keeps stage 0 cleared for FLUSH_HOLD
// further cycles so that instructions already in flight from the fetch path are squashed.
// Ports:
//   CLK, RST     clock / asynchronous active-high reset
//   ACT          unit active; when low the sequencer is frozen
//   flush_req    flush pulse
//   stall0       effective stall of stage 0 (a stalled cycle does not consume hold time)
//   flush_busy   sequencer is in HOLD
//   hold_clear0  request to clear stage 0 this cycle
module riscv_core_pipe_ctrl_flush_fsm
  import riscv_core_pipe_ctrl_pkg::*;
#(
  parameter int FLUSH_HOLD = DEF_FLUSH_HOLD
) (
  input  logic CLK,
  input  logic RST,
  input  logic ACT,
  input  logic flush_req,
  input  logic stall0,
  output logic flush_busy,
  output logic hold_clear0
);

  localparam logic [3:0] HOLD_INIT = 4'(FLUSH_HOLD);

  flush_state_e state, state_nxt;
  logic [3:0]   cnt, cnt_nxt;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (flush_req && ACT && (HOLD_INIT != 4'd0)) begin
          state_nxt = HOLD;
          cnt_nxt   = HOLD_INIT;
        end
      end
      HOLD: begin
        // A fresh flush restarts the shadow window; a stalled stage 0 means
        // its clear did not land, so that cycle does not count.
        if (ACT) begin
          if (flush_req) begin
            cnt_nxt = HOLD_INIT;
          end else if (!stall0) begin
            if (cnt == 4'd1) begin
              state_nxt = IDLE;
              cnt_nxt   = 4'd0;
            end else begin
              cnt_nxt = cnt - 4'd1;
            end
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 4'd0;
      end
    endcase
  end

  assign flush_busy  = (state == HOLD);
  assign hold_clear0 = (state == HOLD);

endmodule

// File: rtl/riscv_core_pipe_ctrl_gen.sv
// Pipeline-control unit for an N-stage in-order core (stage 0 = IF ... N-1 = WB).
// Turns per-stage stall/clear requests into effective stall/clear strobes with
// backward stall propagation, optional bubble insertion and a flush sequencer;
// also keeps a stage-0 stall watchdog and a stall-cycle counter.
// Ports:
//   CLK, RST        clock / asynchronous active-high reset
//   ACT             unit active; 0 forces all stall/clear strobes low
//   stall_req       per-stage stall request
//   clear_req       per-stage clear request
//   flush_req       flush pulse (redirect)
//   flush_stage     highest stage index to flush (saturated to NUM_STAGES-1)
//   wdog_clr        clears stall_timeout and the watchdog count
//   pipe_stall      effective stall per stage (combinational)
//   pipe_clear      effective clear per stage (combinational)
//   flush_busy      flush sequencer in HOLD
//   stall_timeout   sticky watchdog flag
//   stall_cycles    number of cycles with pipe_stall[0]=1, wrapping
module riscv_core_pipe_ctrl_gen
  import riscv_core_pipe_ctrl_pkg::*;
#(
  parameter int NUM_STAGES  = DEF_NUM_STAGES,
  parameter int AUTO_BUBBLE = DEF_AUTO_BUBBLE,
  parameter int FLUSH_HOLD  = DEF_FLUSH_HOLD,
  parameter int WDOG_LIMIT  = DEF_WDOG_LIMIT,
  parameter int CNT_W       = DEF_CNT_W,
  localparam int SW         = clog2_min1(NUM_STAGES)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  ACT,
  input  logic [NUM_STAGES-1:0] stall_req,
  input  logic [NUM_STAGES-1:0] clear_req,
  input  logic                  flush_req,
  input  logic [SW-1:0]         flush_stage,
  input  logic                  wdog_clr,
  output logic [NUM_STAGES-1:0] pipe_stall,
  output logic [NUM_STAGES-1:0] pipe_clear,
  output logic                  flush_busy,
  output logic                  stall_timeout,
  output logic [CNT_W-1:0]      stall_cycles
);

  localparam int WDOG_W = clog2_min1(WDOG_LIMIT + 1);

  logic [NUM_STAGES-1:0] s;
  logic [NUM_STAGES-1:0] fc;
  logic [NUM_STAGES-1:0] b;
  logic                  hold_clear0;
  int                    fs_lim;
  logic [WDOG_W-1:0]     wdog_cnt;

  // Stall propagates backwards: a stalled stage holds every older stage too.
  always_comb begin
    s[NUM_STAGES-1] = stall_req[NUM_STAGES-1];
    for (int i = NUM_STAGES - 2; i >= 0; i--) begin
      s[i] = stall_req[i] | s[i+1];
    end
  end

  always_comb begin
    fs_lim = int'(flush_stage);
    if (fs_lim > NUM_STAGES - 1) fs_lim = NUM_STAGES - 1;
  end

  always_comb begin
    fc = '0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      fc[i] = flush_req & ACT & (i <= fs_lim);
    end
    fc[0] = fc[0] | hold_clear0;
  end

  // Bubble: when stage i holds but i+1 moves on, i+1 must not re-execute its old content.
  always_comb begin
    b = '0;
    for (int i = 0; i < NUM_STAGES - 1; i++) begin
      b[i+1] = (AUTO_BUBBLE != 0) & s[i] & ~s[i+1];
    end
  end

  assign pipe_stall = ACT ? s : '0;
  assign pipe_clear = ACT ? (~s & (clear_req | fc | b)) : '0;

  riscv_core_pipe_ctrl_flush_fsm #(
    .FLUSH_HOLD (FLUSH_HOLD)
  ) u_flush_fsm (
    .CLK         (CLK),
    .RST         (RST),
    .ACT         (ACT),
    .flush_req   (flush_req),
    .stall0      (pipe_stall[0]),
    .flush_busy  (flush_busy),
    .hold_clear0 (hold_clear0)
  );

  // Watchdog: counts consecutive stage-0 stall cycles, saturating at the limit.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wdog_cnt      <= '0;
      stall_timeout <= 1'b0;
    end else if (wdog_clr) begin
      wdog_cnt      <= '0;
      stall_timeout <= 1'b0;
    end else if (pipe_stall[0]) begin
      if (int'(wdog_cnt) < WDOG_LIMIT) begin
        wdog_cnt <= wdog_cnt + 1'b1;
        if (int'(wdog_cnt) + 1 == WDOG_LIMIT) stall_timeout <= 1'b1;
      end
    end else begin
      wdog_cnt <= '0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stall_cycles <= '0;
    end else begin
      stall_cycles <= stall_cycles + {{(CNT_W-1){1'b0}}, pipe_stall[0]};
    end
  end

endmodule

// File: tb/tb_riscv_core_pipe_ctrl_gen.sv
module tb_riscv_core_pipe_ctrl_gen;

  logic        CLK;
  logic        RST;
  logic        ACT;
  logic [4:0]  stall_req;
  logic [4:0]  clear_req;
  logic        flush_req;
  logic [2:0]  flush_stage;
  logic        wdog_clr;
  logic [4:0]  pipe_stall;
  logic [4:0]  pipe_clear;
  logic        flush_busy;
  logic        stall_timeout;
  logic [31:0] stall_cycles;

  int n_vec;
  int n_mis;

  riscv_core_pipe_ctrl_gen #(
    .NUM_STAGES  (5),
    .AUTO_BUBBLE (1),
    .FLUSH_HOLD  (2),
    .WDOG_LIMIT  (4),
    .CNT_W       (32)
  ) dut (
    .CLK           (CLK),
    .RST           (RST),
    .ACT           (ACT),
    .stall_req     (stall_req),
    .clear_req     (clear_req),
    .flush_req     (flush_req),
    .flush_stage   (flush_stage),
    .wdog_clr      (wdog_clr),
    .pipe_stall    (pipe_stall),
    .pipe_clear    (pipe_clear),
    .flush_busy    (flush_busy),
    .stall_timeout (stall_timeout),
    .stall_cycles  (stall_cycles)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs are sampled 2-3 ns later.
  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  initial begin
    n_vec = 0;
    n_mis = 0;
    RST = 1'b1; ACT = 1'b0; stall_req = '0; clear_req = '0;
    flush_req = 1'b0; flush_stage = '0; wdog_clr = 1'b0;

    // Reset state
    #3;
    chk("rst_busy",    32'(flush_busy),    32'd0);
    chk("rst_timeout", 32'(stall_timeout), 32'd0);
    chk("rst_cycles",  stall_cycles,       32'd0);
    chk("rst_clear",   32'(pipe_clear),    32'd0);
    ACT = 1'b1; stall_req = 5'b00100;
    #1;
    chk("rst_live_stall", 32'(pipe_stall), 32'(5'b00111));
    stall_req = '0;
    tick();
    RST = 1'b0;
    #1;

    // 1: stall in EX propagates back, bubble into ME
    stall_req = 5'b00100;
    #1;
    chk("t1_stall", 32'(pipe_stall), 32'(5'b00111));
    chk("t1_clear", 32'(pipe_clear), 32'(5'b01000));

    // 2: stall beats clear on stage 1; bubble on stage 2
    stall_req = 5'b00010; clear_req = 5'b00010;
    #1;
    chk("t2_stall", 32'(pipe_stall), 32'(5'b00011));
    chk("t2_clear", 32'(pipe_clear), 32'(5'b00100));

    // flush_stage beyond the last stage saturates (combinational only, no edge)
    stall_req = '0; clear_req = '0;
    flush_req = 1'b1; flush_stage = 3'd7;
    #1;
    chk("sat_clear", 32'(pipe_clear), 32'(5'b11111));
    flush_req = 1'b0; flush_stage = '0;
    tick();

    // 5: watchdog, stall held for 4 edges
    stall_req = 5'b00001;
    tick(); tick(); tick();
    chk("t5_timeout_3", 32'(stall_timeout), 32'd0);
    tick();
    chk("t5_timeout_4", 32'(stall_timeout), 32'd1);
    chk("t5_cycles",    stall_cycles,       32'd4);
    stall_req = '0; wdog_clr = 1'b1;
    tick();
    wdog_clr = 1'b0;
    chk("t5_wdog_clr", 32'(stall_timeout), 32'd0);
    chk("t5_cycles_hold", stall_cycles, 32'd4);

    // 3: flush stages 0..2, two-cycle hold
    flush_req = 1'b1; flush_stage = 3'd2;
    #1;
    chk("t3_T_clear", 32'(pipe_clear), 32'(5'b00111));
    chk("t3_T_busy",  32'(flush_busy), 32'd0);
    tick();
    flush_req = 1'b0;
    #1;
    chk("t3_T1_clear", 32'(pipe_clear), 32'(5'b00001));
    chk("t3_T1_busy",  32'(flush_busy), 32'd1);
    tick();
    chk("t3_T2_clear", 32'(pipe_clear), 32'(5'b00001));
    chk("t3_T2_busy",  32'(flush_busy), 32'd1);
    tick();
    chk("t3_T3_busy",  32'(flush_busy), 32'd0);
    chk("t3_T3_clear", 32'(pipe_clear), 32'd0);

    // 4: as 3, with stage 0 stalled on T+1 so hold extends one cycle
    flush_req = 1'b1; flush_stage = 3'd2;
    #1;
    chk("t4_T_clear", 32'(pipe_clear), 32'(5'b00111));
    tick();
    flush_req = 1'b0; stall_req = 5'b00001;
    #1;
    chk("t4_T1_clear", 32'(pipe_clear), 32'(5'b00010));
    chk("t4_T1_busy",  32'(flush_busy), 32'd1);
    tick();
    stall_req = '0;
    #1;
    chk("t4_T2_clear", 32'(pipe_clear), 32'(5'b00001));
    chk("t4_T2_busy",  32'(flush_busy), 32'd1);
    tick();
    chk("t4_T3_busy",  32'(flush_busy), 32'd1);
    tick();
    chk("t4_T4_busy",  32'(flush_busy), 32'd0);
    chk("t4_cycles",   stall_cycles,    32'd5);

    // ACT=0 freezes the hold sequence
    flush_req = 1'b1; flush_stage = 3'd0;
    tick();
    flush_req = 1'b0; ACT = 1'b0;
    #1;
    chk("frz_clear", 32'(pipe_clear), 32'd0);
    tick(); tick();
    chk("frz_busy", 32'(flush_busy), 32'd1);
    ACT = 1'b1;
    #1;
    chk("frz_resume_clear", 32'(pipe_clear), 32'(5'b00001));
    tick();
    chk("frz_busy_1", 32'(flush_busy), 32'd1);
    tick();
    chk("frz_busy_done", 32'(flush_busy), 32'd0);

    // 6: reset during HOLD drops everything immediately
    flush_req = 1'b1; flush_stage = 3'd4;
    tick();
    flush_req = 1'b0;
    #1;
    chk("t6_busy_pre",  32'(flush_busy), 32'd1);
    chk("t6_clear_pre", 32'(pipe_clear), 32'(5'b00001));
    RST = 1'b1;
    #1;
    chk("t6_busy_rst",  32'(flush_busy), 32'd0);
    chk("t6_clear_rst", 32'(pipe_clear), 32'd0);
    chk("t6_cycles_rst", stall_cycles,   32'd0);

    // ACT=0 masks every request
    ACT = 1'b0; stall_req = 5'b11111; clear_req = 5'b11111; flush_req = 1'b1;
    #1;
    chk("t6_act0_stall", 32'(pipe_stall), 32'd0);
    chk("t6_act0_clear", 32'(pipe_clear), 32'd0);
    RST = 1'b0;
    tick();
    chk("t6_act0_busy",   32'(flush_busy), 32'd0);
    chk("t6_act0_cycles", stall_cycles,    32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "bench time limit");
  end

endmodule
